// File: rtl/shift_rotate_issue.sv
// Command FIFO feeding the combinational ShiftRotate datapath, plus a registered
// result stage with its own valid/ready handshake and pass-through tag.
module shift_rotate_issue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_data,
  input  logic [4:0]               cmd_amount,
  input  logic                     cmd_direction,
  input  logic                     cmd_type,
  input  logic [3:0]               cmd_tag,
  output logic [31:0]              sr_data_in,
  output logic [4:0]               sr_rotate_amount,
  output logic                     sr_rotate_direction,
  output logic                     sr_rotate_type,
  input  logic [31:0]              sr_data_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [3:0]               res_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 32 + 5 + 1 + 1 + 4;

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          res_valid_reg;
  logic [31:0]   res_data_reg;
  logic [3:0]    res_tag_reg;
  logic [EW-1:0] entries [DEPTH];
  logic [EW-1:0] head;
  logic          push, issue;

  assign cmd_ready = (count_reg < CW'(DEPTH)) & ~flush;
  assign push      = cmd_valid & cmd_ready;
  assign issue     = (count_reg != '0) & (~res_valid_reg | res_ready);

  // Each entry is its own register so reset can clear storage asynchronously.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [EW-1:0] entry_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          entry_reg <= '0;
        else if (push && (wr_ptr_reg == AW'(gi)))
          entry_reg <= {cmd_data, cmd_amount, cmd_direction, cmd_type, cmd_tag};
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign head                = entries[rd_ptr_reg];
  assign sr_data_in          = head[42:11];
  assign sr_rotate_amount    = head[10:6];
  assign sr_rotate_direction = head[5];
  assign sr_rotate_type      = head[4];

  always_comb begin
    count_next = count_reg;
    case ({push, issue})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Flush clears occupancy and result validity but leaves res_data/res_tag intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_tag_reg   <= '0;
    end else if (flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      res_valid_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (issue) begin
        rd_ptr_reg    <= rd_ptr_reg + AW'(1);
        res_data_reg  <= sr_data_out;
        res_tag_reg   <= head[3:0];
        res_valid_reg <= 1'b1;
      end else if (res_valid_reg && res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_tag   = res_tag_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_shift_rotate_issue.sv
// Directed bench for shift_rotate_issue (DEPTH=4) driving a behavioural ShiftRotate.
module tb_shift_rotate_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_data = '0;
  logic [4:0]  cmd_amount = '0;
  logic        cmd_direction = 1'b0;
  logic        cmd_type = 1'b0;
  logic [3:0]  cmd_tag = '0;
  logic [31:0] sr_data_in;
  logic [4:0]  sr_rotate_amount;
  logic        sr_rotate_direction;
  logic        sr_rotate_type;
  logic [31:0] sr_data_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] v_data [8];
  logic [4:0]  v_amt  [8];
  logic        v_dir  [8];
  logic        v_typ  [8];
  logic [3:0]  v_tag  [8];
  logic [31:0] v_exp  [8];

  always #5 clk = ~clk;

  shift_rotate_issue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_amount(cmd_amount), .cmd_direction(cmd_direction), .cmd_type(cmd_type),
    .cmd_tag(cmd_tag),
    .sr_data_in(sr_data_in), .sr_rotate_amount(sr_rotate_amount),
    .sr_rotate_direction(sr_rotate_direction), .sr_rotate_type(sr_rotate_type),
    .sr_data_out(sr_data_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .count(count)
  );

  // Behavioural ShiftRotate: direction 0 = left, type 1 = rotate.
  logic [63:0] dd, dd_l, dd_r;
  always_comb begin
    dd   = {sr_data_in, sr_data_in};
    dd_l = dd << sr_rotate_amount;
    dd_r = dd >> sr_rotate_amount;
    if (sr_rotate_type)
      sr_data_out = sr_rotate_direction ? dd_r[31:0] : dd_l[63:32];
    else
      sr_data_out = sr_rotate_direction ? (sr_data_in >> sr_rotate_amount)
                                        : (sr_data_in << sr_rotate_amount);
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a,
                       input logic dir, input logic typ, input logic [3:0] t);
    cmd_valid = v; cmd_data = d; cmd_amount = a;
    cmd_direction = dir; cmd_type = typ; cmd_tag = t;
  endtask

  task automatic run_stream(input int n, input string name);
    res_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, v_data[i], v_amt[i], v_dir[i], v_typ[i], v_tag[i]);
      @(negedge clk);
      if (i == 0) chk($sformatf("%s_first_latency", name), {31'b0, res_valid}, 32'd0);
      else begin
        chk($sformatf("%s_valid%0d", name, i-1), {31'b0, res_valid}, 32'd1);
        chk($sformatf("%s_data%0d", name, i-1), res_data, v_exp[i-1]);
        chk($sformatf("%s_tag%0d", name, i-1), {28'b0, res_tag}, {28'b0, v_tag[i-1]});
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_valid%0d", name, n-1), {31'b0, res_valid}, 32'd1);
    chk($sformatf("%s_data%0d", name, n-1), res_data, v_exp[n-1]);
    chk($sformatf("%s_tag%0d", name, n-1), {28'b0, res_tag}, {28'b0, v_tag[n-1]});
    @(negedge clk);
    chk($sformatf("%s_drained_valid", name), {31'b0, res_valid}, 32'd0);
    chk($sformatf("%s_drained_count", name), {29'b0, count}, 32'd0);
  endtask

  initial begin
    // Reset values, applied asynchronously before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_sr_data_in", sr_data_in, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_tag", {28'b0, res_tag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back SL, SR, RL, RR of A5A5A5A5 by 4
    for (int i = 0; i < 4; i++) begin
      v_data[i] = 32'hA5A5A5A5; v_amt[i] = 5'd4; v_tag[i] = 4'(i);
      v_dir[i] = i[0]; v_typ[i] = i[1];
    end
    v_exp[0] = 32'h5A5A5A50; v_exp[1] = 32'h0A5A5A5A;
    v_exp[2] = 32'h5A5A5A5A; v_exp[3] = 32'h5A5A5A5A;
    run_stream(4, "b2b");

    // Back-pressure to full: 6 offered, 5 accepted
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(32'h11111111 * (i + 1)), 5'd0, 1'b0, 1'b0, 4'(4 + i));
      chk($sformatf("bp_cmd_ready%0d", i), {31'b0, cmd_ready}, (i < 5) ? 32'd1 : 32'd0);
      @(negedge clk);
      if (i >= 1) begin
        chk($sformatf("bp_frozen_data%0d", i), res_data, 32'h11111111);
        chk($sformatf("bp_frozen_tag%0d", i), {28'b0, res_tag}, 32'd4);
      end
    end
    chk("bp_full_count", {29'b0, count}, 32'd4);
    chk("bp_full_ready", {31'b0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("bp_drain_valid%0d", j), {31'b0, res_valid}, 32'd1);
      chk($sformatf("bp_drain_data%0d", j), res_data, 32'(32'h11111111 * (j + 1)));
      chk($sformatf("bp_drain_tag%0d", j), {28'b0, res_tag}, 32'(4 + j));
      if (j == 1) chk("bp_ready_reassert", {31'b0, cmd_ready}, 32'd1);
    end
    @(negedge clk);
    chk("bp_end_valid", {31'b0, res_valid}, 32'd0);
    chk("bp_end_count", {29'b0, count}, 32'd0);

    // Simultaneous push and pop at count=2
    res_ready = 1'b0;
    drive(1'b1, 32'h000000FF, 5'd8, 1'b0, 1'b0, 4'd10); @(negedge clk);
    drive(1'b1, 32'hF0000000, 5'd4, 1'b1, 1'b0, 4'd11); @(negedge clk);
    drive(1'b1, 32'h80000001, 5'd1, 1'b0, 1'b1, 4'd12); @(negedge clk);
    chk("pp_pre_count", {29'b0, count}, 32'd2);
    chk("pp_pre_data", res_data, 32'h0000FF00);
    res_ready = 1'b1;
    drive(1'b1, 32'h80000001, 5'd1, 1'b1, 1'b1, 4'd13); @(negedge clk);
    chk("pp_count", {29'b0, count}, 32'd2);
    chk("pp_data1", res_data, 32'h0F000000);
    chk("pp_tag1", {28'b0, res_tag}, 32'd11);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pp_data2", res_data, 32'h00000003);
    chk("pp_tag2", {28'b0, res_tag}, 32'd12);
    @(negedge clk);
    chk("pp_data3", res_data, 32'hC0000000);
    chk("pp_tag3", {28'b0, res_tag}, 32'd13);
    @(negedge clk);
    chk("pp_end_valid", {31'b0, res_valid}, 32'd0);

    // Flush with 3 queued and an offered command
    res_ready = 1'b0;
    drive(1'b1, 32'h00000001, 5'd1, 1'b0, 1'b0, 4'd1); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000BB00 + 32'(i), 5'd0, 1'b0, 1'b0, 4'(2 + i));
      @(negedge clk);
    end
    chk("fl_pre_count", {29'b0, count}, 32'd3);
    flush = 1'b1;
    drive(1'b1, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 4'd15);
    #1 chk("fl_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("fl_count", {29'b0, count}, 32'd0);
    chk("fl_res_valid", {31'b0, res_valid}, 32'd0);
    chk("fl_res_data_kept", res_data, 32'h00000002);
    flush = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("fl_no_ghost_valid", {31'b0, res_valid}, 32'd0);
    chk("fl_no_ghost_count", {29'b0, count}, 32'd0);

    // Amount boundaries
    v_data[0] = 32'h12345678; v_amt[0] = 5'd0;  v_dir[0] = 1'b0; v_typ[0] = 1'b0; v_exp[0] = 32'h12345678;
    v_data[1] = 32'h12345678; v_amt[1] = 5'd0;  v_dir[1] = 1'b1; v_typ[1] = 1'b0; v_exp[1] = 32'h12345678;
    v_data[2] = 32'h12345678; v_amt[2] = 5'd31; v_dir[2] = 1'b0; v_typ[2] = 1'b0; v_exp[2] = 32'h00000000;
    v_data[3] = 32'h12345678; v_amt[3] = 5'd31; v_dir[3] = 1'b1; v_typ[3] = 1'b0; v_exp[3] = 32'h00000000;
    v_data[4] = 32'hDEADBEEF; v_amt[4] = 5'd31; v_dir[4] = 1'b0; v_typ[4] = 1'b1; v_exp[4] = 32'hEF56DF77;
    v_data[5] = 32'hDEADBEEF; v_amt[5] = 5'd8;  v_dir[5] = 1'b0; v_typ[5] = 1'b1; v_exp[5] = 32'hADBEEFDE;
    for (int i = 0; i < 6; i++) v_tag[i] = 4'(8 + i);
    run_stream(6, "amt");

    // Async reset mid-operation
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000AAA0 + 32'(i), 5'd0, 1'b0, 1'b0, 4'(i));
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("ar_pre_count", {29'b0, count}, 32'd3);
    chk("ar_pre_valid", {31'b0, res_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_count", {29'b0, count}, 32'd0);
    chk("ar_res_valid", {31'b0, res_valid}, 32'd0);
    chk("ar_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("ar_sr_data_in", sr_data_in, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_after_valid", {31'b0, res_valid}, 32'd0);
    chk("ar_after_count", {29'b0, count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_rotate_issue.md
# shift_rotate_issue

Command-queue and result-register stage directly upstream and downstream of the combinational ShiftRotate datapath. Buffers shift/rotate commands from a valid/ready producer in a DEPTH-entry FIFO and drives the queue head onto ShiftRotate's inputs. It captures ShiftRotate's output into a registered result with its own valid/ready handshake and a pass-through tag. This turns the single-cycle combinational shifter into a pipelined, back-pressurable unit.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of FIFO and result register
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_data  in  32  operand
- cmd_amount  in  5  shift/rotate amount 0..31
- cmd_direction  in  1  0 = left, 1 = right
- cmd_type  in  1  0 = shift, 1 = rotate
- cmd_tag  in  4  opaque ID returned with result
- sr_data_in  out  32  to ShiftRotate data_in
- sr_rotate_amount  out  5  to ShiftRotate rotate_amount
- sr_rotate_direction  out  1  to ShiftRotate rotate_direction
- sr_rotate_type  out  1  to ShiftRotate rotate_type
- sr_data_out  in  32  from ShiftRotate data_out
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  32  registered ShiftRotate output
- res_tag  out  4  tag of that command
- count  out  $clog2(DEPTH)+1  FIFO occupancy 0..DEPTH

## Operation
- FIFO: wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap), count register. Storage holds {data, amount, direction, type, tag}.
- Push: cmd_valid & cmd_ready. Data is written at wr_ptr, and wr_ptr increments.
- cmd_ready = (count < DEPTH) & ~flush. It is registered-state-based only; there is no same-cycle bypass from a pop.
- sr_* outputs are the storage fields at rd_ptr. They are driven combinationally from registers, so they stay stable for a whole cycle.
- Issue condition: count ≠ 0 & (~res_valid | res_ready). On issue:
  - res_data ← sr_data_out
  - res_tag ← head tag
  - res_valid ← 1
  - rd_ptr increments
- Result consumed without issue (res_valid & res_ready & count = 0): res_valid ← 0.
- Count update:
  - push & issue: unchanged
  - push only: +1
  - issue only: −1
- Results leave strictly in acceptance order.
- res_data and res_tag hold unchanged while res_valid & ~res_ready.
- Flush: count, pointers and res_valid go to 0 at the edge. A cmd_valid in the flush cycle is dropped (cmd_ready = 0). res_data and res_tag keep their old values.
- Priority: rst > flush > push/issue.

## Timing
- Reset (async assert, applies immediately):
  - count = 0, pointers = 0, storage = 0, so all sr_* = 0
  - res_valid = 0, res_data = 0, res_tag = 0, cmd_ready = 1
- Reset mid-operation discards all queued and pending results; nothing is issued after deassertion until new pushes arrive.
- Latency: a command accepted at edge N into an empty FIFO with an empty or draining result register issues at edge N+1. res_valid is high after edge N+1.
- Throughput: one result per cycle with res_ready held high and cmd_valid held high.
- Full: count = DEPTH drops cmd_ready in the same cycle. cmd_ready reasserts the cycle after count falls below DEPTH.
- Capacity under full back-pressure is DEPTH + 1 commands (DEPTH in the FIFO, 1 in the result register).
- Empty FIFO: sr_* show the stale entry at rd_ptr; they are ignored because no issue occurs.
- Amount 0 passes the operand through unchanged via ShiftRotate; this stage applies no special case.

## Test plan
Bench instantiates shift_rotate_issue (DEPTH=4) connected to ShiftRotate.

- **Async reset mid-operation:** assert rst between edges with 3 entries queued and res_valid=1 → count=0, res_valid=0, cmd_ready=1, sr_data_in=0 immediately; no result after release.
- **Back-to-back, full throughput:** res_ready=1; push A5A5A5A5, amount 4, with {SL, SR, RL, RR}, tags 0..3, on consecutive cycles → results 5A5A5A50, 0A5A5A5A, 5A5A5A5A, 5A5A5A5A with tags 0..3, the first one cycle after acceptance, then one per cycle.
- **Back-pressure to full:** res_ready=0; push 6 commands → 5 accepted, then cmd_ready=0 and count=4, with res_data frozen on the first result. Raise res_ready → all 5 results drain in order and cmd_ready reasserts.
- **Simultaneous push and pop:** count=2, push while a result is consumed → count stays 2 and ordering is preserved.
- **Flush:** flush=1 with cmd_valid=1 and count=3 → next cycle count=0, res_valid=0, and the offered command never appears.
- **Amount boundaries:**
  - 12345678, amount 0, SL and SR → 12345678
  - 12345678, amount 31, SL → 00000000; SR → 00000000
  - DEADBEEF, amount 31, RL → EF56DF77
  - DEADBEEF, amount 8, RL → ADBEEFDE
